// File: rtl/t05_bitstream_arbiter.sv
// ----------------------------------------------------------------------------
// t05_bitstream_arbiter
//
// Shares one packed SRAM write port between two serial bit producers
// (src0 = header synthesis, src1 = codeword translation). One source owns the
// packer at a time. Its accepted bits are packed MSB-first into WORD_W-bit
// words. Each completed word is written through a req/ack handshake at an
// auto-incrementing address. On flush, the final partial word is zero-padded
// and written, and then done pulses for one cycle.
//
// Configuration macro:
//   T05_BITARB_RR_EN  defined   -> round-robin arbitration between sources
//                     undefined -> fixed priority, src0 wins
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   src_en     [1:0] per-source bit valid / request
//   src_bit    [1:0] per-source serial data bit
//   src_last   [1:0] per-source end-of-segment, releases the grant
//   src_ready  [1:0] bit accepted when en && ready
//   grant      [1:0] one-hot current owner, 2'b00 when idle
//   flush      end-of-stream request (honoured only in IDLE)
//   wr_req     write request, held until wr_ack
//   wr_addr    [ADDR_W-1:0] word address
//   wr_data    [WORD_W-1:0] packed word
//   wr_ack     write accepted, one-cycle pulse
//   busy       not IDLE, or a word is still pending
//   done       one-cycle pulse after flush has drained
// ----------------------------------------------------------------------------
module t05_bitstream_arbiter #(
    parameter int                 WORD_W    = 32,
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = 32'h3300_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        src_en,
    input  logic [1:0]        src_bit,
    input  logic [1:0]        src_last,
    output logic [1:0]        src_ready,
    output logic [1:0]        grant,
    input  logic              flush,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    input  logic              wr_ack,
    output logic              busy,
    output logic              done
);

    localparam int                CNT_W     = $clog2(WORD_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(WORD_W / 8);
    localparam logic [CNT_W:0]    WORD_BITS = (CNT_W + 1)'(WORD_W);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        GRANT0     = 3'd1,
        GRANT1     = 3'd2,
        FLUSH_LOAD = 3'd3,
        FLUSH_WAIT = 3'd4,
        DONE       = 3'd5
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WORD_W-1:0] pack_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              pend_v_r;
    logic [WORD_W-1:0] pend_data_r;
    logic [ADDR_W-1:0] addr_r;

    logic              stall_s;
    logic              acc_s;
    logic              bit_s;
    logic              last_s;
    logic              ack_s;
    logic              word_done_s;
    logic              flush_load_s;
    logic              pick1_s;
    logic [CNT_W:0]    pad_shift_s;

    // A full shift register can only take its last bit if the pending slot
    // frees up this cycle (or is already free).
    assign stall_s      = (cnt_r == CNT_MAX) && pend_v_r && !wr_ack;
    assign src_ready    = {(state_r == GRANT1) && !stall_s, (state_r == GRANT0) && !stall_s};
    assign acc_s        = |(src_en & src_ready);
    assign bit_s        = (state_r == GRANT1) ? src_bit[1] : src_bit[0];
    assign last_s       = (state_r == GRANT1) ? src_last[1] : src_last[0];
    assign ack_s        = wr_ack && pend_v_r;
    assign word_done_s  = acc_s && (cnt_r == CNT_MAX);
    assign flush_load_s = (state_r == FLUSH_LOAD) && !pend_v_r && (cnt_r != CNT_ZERO);
    assign pad_shift_s  = WORD_BITS - {1'b0, cnt_r};

    assign grant   = {state_r == GRANT1, state_r == GRANT0};
    assign wr_req  = pend_v_r;
    assign wr_addr = addr_r;
    assign wr_data = pend_data_r;
    assign busy    = (state_r != IDLE) || pend_v_r;
    assign done    = (state_r == DONE);

`ifdef T05_BITARB_RR_EN
    // last_served_r = 1 means src1 released last, so src0 wins the next tie.
    logic last_served_r;

    // Remember which source released the grant most recently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_served_r <= 1'b1;
        end else if ((state_r == GRANT0 || state_r == GRANT1) && last_s) begin
            last_served_r <= (state_r == GRANT1);
        end else begin
            last_served_r <= last_served_r;
        end
    end

    assign pick1_s = !last_served_r;
`else
    assign pick1_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: flush beats requests in IDLE; ties go to the arbiter.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (flush) begin
                    state_nxt_s = FLUSH_LOAD;
                end else if (src_en[0] && src_en[1]) begin
                    state_nxt_s = pick1_s ? GRANT1 : GRANT0;
                end else if (src_en[0]) begin
                    state_nxt_s = GRANT0;
                end else if (src_en[1]) begin
                    state_nxt_s = GRANT1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GRANT0, GRANT1: begin
                if (last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            FLUSH_LOAD: begin
                if (!pend_v_r) begin
                    state_nxt_s = FLUSH_WAIT;
                end else begin
                    state_nxt_s = FLUSH_LOAD;
                end
            end
            FLUSH_WAIT: begin
                if (!pend_v_r) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = FLUSH_WAIT;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Bit packer: shift in accepted bits, clear when a stream finishes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack_r <= {WORD_W{1'b0}};
            cnt_r  <= CNT_ZERO;
        end else if (state_r == DONE) begin
            pack_r <= {WORD_W{1'b0}};
            cnt_r  <= CNT_ZERO;
        end else if (acc_s) begin
            pack_r <= {pack_r[WORD_W-2:0], bit_s};
            cnt_r  <= word_done_s ? CNT_ZERO : (cnt_r + CNT_ONE);
        end else if (flush_load_s) begin
            pack_r <= pack_r;
            cnt_r  <= CNT_ZERO;
        end else begin
            pack_r <= pack_r;
            cnt_r  <= cnt_r;
        end
    end

    // Pending word slot: a new load wins over a same-cycle ack so the ack
    // retires the old word while the new one takes its place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_v_r    <= 1'b0;
            pend_data_r <= {WORD_W{1'b0}};
        end else if (word_done_s) begin
            pend_v_r    <= 1'b1;
            pend_data_r <= {pack_r[WORD_W-2:0], bit_s};
        end else if (flush_load_s) begin
            pend_v_r    <= 1'b1;
            pend_data_r <= pack_r << pad_shift_s;
        end else if (ack_s) begin
            pend_v_r    <= 1'b0;
            pend_data_r <= pend_data_r;
        end else begin
            pend_v_r    <= pend_v_r;
            pend_data_r <= pend_data_r;
        end
    end

    // Write address: advance per retired word, rewind at end of stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r <= BASE_ADDR;
        end else if (state_r == DONE) begin
            addr_r <= BASE_ADDR;
        end else if (ack_s) begin
            addr_r <= addr_r + ADDR_STEP;
        end else begin
            addr_r <= addr_r;
        end
    end

endmodule

// File: tb/tb_t05_bitstream_arbiter.sv
module tb_t05_bitstream_arbiter;

    localparam logic [31:0] BASE = 32'h3300_0000;

    logic        clk;
    logic        rst;
    logic [1:0]  src_en;
    logic [1:0]  src_bit;
    logic [1:0]  src_last;
    logic [1:0]  src_ready;
    logic [1:0]  grant;
    logic        flush;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb_data[$];
    logic [31:0] sb_addr[$];
    logic [31:0] mdl_pack;
    int          mdl_cnt;
    logic [31:0] mdl_addr;
    logic        auto_ack;
    logic        acc_flag;

    t05_bitstream_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .src_en    (src_en),
        .src_bit   (src_bit),
        .src_last  (src_last),
        .src_ready (src_ready),
        .grant     (grant),
        .flush     (flush),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic mdl_accept(input logic b);
        mdl_pack = {mdl_pack[30:0], b};
        mdl_cnt++;
        if (mdl_cnt == 32) begin
            sb_data.push_back(mdl_pack);
            sb_addr.push_back(mdl_addr);
            mdl_addr = mdl_addr + 32'd4;
            mdl_cnt  = 0;
        end
    endtask

    task automatic mdl_flush();
        if (mdl_cnt > 0) begin
            sb_data.push_back(mdl_pack << (32 - mdl_cnt));
            sb_addr.push_back(mdl_addr);
            mdl_addr = mdl_addr + 32'd4;
        end
        mdl_cnt = 0;
    endtask

    task automatic mdl_clear();
        mdl_pack = 32'h0;
        mdl_cnt  = 0;
        mdl_addr = BASE;
    endtask

    // One clock cycle: drive at negedge, settle, update model, check writes.
    task automatic cyc(input logic [1:0] en, input logic [1:0] b, input logic [1:0] l,
                       input logic fl, input logic ack);
        logic [31:0] ed;
        logic [31:0] ea;
        @(negedge clk);
        src_en   = en;
        src_bit  = b;
        src_last = l;
        flush    = fl;
        wr_ack   = ack | (auto_ack & wr_req & ~wr_ack);
        #1;
        acc_flag = 1'b0;
        for (int n = 0; n < 2; n++) begin
            if (en[n] && src_ready[n]) begin
                acc_flag = 1'b1;
                mdl_accept(b[n]);
            end
        end
        if (wr_req && wr_ack) begin
            checks++;
            if (sb_data.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_write: got data %h addr %h, expected no write", wr_data, wr_addr);
            end else begin
                ed = sb_data.pop_front();
                ea = sb_addr.pop_front();
                if (wr_data !== ed || wr_addr !== ea) begin
                    errors++;
                    $display("FAIL sb_write: got data %h addr %h, expected data %h addr %h",
                             wr_data, wr_addr, ed, ea);
                end
            end
        end
    endtask

    task automatic do_flush();
        logic got;
        auto_ack = 1'b1;
        cyc(2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        mdl_flush();
        got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
            if (done === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL flush_done_timeout: got no done, expected done within 100 cycles");
        end
        mdl_clear();
        cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    endtask

    // Send one bit from source n, retrying until accepted.
    task automatic send_bit(input int n, input logic b, input logic l);
        logic got;
        logic [1:0] en;
        logic [1:0] bv;
        logic [1:0] lv;
        en = (n == 0) ? 2'b01 : 2'b10;
        bv = (n == 0) ? {1'b0, b} : {b, 1'b0};
        lv = (n == 0) ? {1'b0, l} : {l, 1'b0};
        got = 1'b0;
        for (int t = 0; t < 8 && !got; t++) begin
            cyc(en, bv, lv, 1'b0, 1'b0);
            got = acc_flag;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL send_bit_timeout: got no ready on src%0d, expected acceptance", n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        src_en = 2'b00; src_bit = 2'b00; src_last = 2'b00; flush = 1'b0;
        wr_ack = 1'b0; auto_ack = 1'b0;
        mdl_clear();
        cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        checks++; if (grant !== 2'b00)     begin errors++; $display("FAIL rst_grant: got %b expected 00", grant); end
        checks++; if (src_ready !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b expected 00", src_ready); end
        checks++; if (wr_req !== 1'b0)     begin errors++; $display("FAIL rst_wr_req: got %b expected 0", wr_req); end
        checks++; if (wr_addr !== BASE)    begin errors++; $display("FAIL rst_wr_addr: got %h expected %h", wr_addr, BASE); end
        checks++; if (wr_data !== 32'h0)   begin errors++; $display("FAIL rst_wr_data: got %h expected 0", wr_data); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0)       begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
        rst = 1'b0;
    endtask

    task automatic test_single_word();
        logic [31:0] d;
        d = 32'hA5A5_0F0F;
        auto_ack = 1'b0;
        for (int i = 31; i >= 0; i--) send_bit(0, d[i], (i == 0));
        cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        checks++; if (wr_req !== 1'b1)   begin errors++; $display("FAIL single_wr_req: got %b expected 1", wr_req); end
        checks++; if (wr_data !== d)     begin errors++; $display("FAIL single_wr_data: got %h expected %h", wr_data, d); end
        checks++; if (wr_addr !== BASE)  begin errors++; $display("FAIL single_wr_addr: got %h expected %h", wr_addr, BASE); end
        checks++; if (grant !== 2'b00)   begin errors++; $display("FAIL single_grant_release: got %b expected 00", grant); end
        checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL single_busy_pend: got %b expected 1", busy); end
        cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
        cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        checks++; if (wr_addr !== BASE + 32'd4) begin errors++; $display("FAIL single_addr_inc: got %h expected %h", wr_addr, BASE + 32'd4); end
        checks++; if (wr_req !== 1'b0)   begin errors++; $display("FAIL single_req_drop: got %b expected 0", wr_req); end
    endtask

    task automatic test_arbitration();
        logic [1:0] exp2;
`ifdef T05_BITARB_RR_EN
        exp2 = 2'b10;
`else
        exp2 = 2'b01;
`endif
        auto_ack = 1'b1;
        cyc(2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL arb_idle0: got %b expected 00", grant); end
        cyc(2'b11, 2'b01, 2'b01, 1'b0, 1'b0);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL arb_first: got %b expected 01", grant); end
        checks++; if (src_ready !== 2'b01) begin errors++; $display("FAIL arb_ready_first: got %b expected 01", src_ready); end
        cyc(2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL arb_idle1: got %b expected 00", grant); end
        cyc(2'b11, 2'b11, 2'b11, 1'b0, 1'b0);
        checks++; if (grant !== exp2) begin errors++; $display("FAIL arb_second: got %b expected %b", grant, exp2); end
        cyc(2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL arb_idle2: got %b expected 00", grant); end
        cyc(2'b11, 2'b10, 2'b11, 1'b0, 1'b0);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL arb_third: got %b expected 01", grant); end
        cyc(2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL arb_idle3: got %b expected 00", grant); end
        cyc(2'b10, 2'b10, 2'b10, 1'b0, 1'b0);
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL arb_src1_only: got %b expected 10", grant); end
        checks++; if (src_ready !== 2'b10) begin errors++; $display("FAIL arb_ready_src1: got %b expected 10", src_ready); end
        cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL arb_release: got %b expected 00", grant); end
        do_flush();
    endtask

    task automatic test_back_to_back();
        logic [31:0] wa;
        logic [31:0] wb;
        logic        bt;
        wa = 32'h1234_5678;
        wb = 32'hCAFE_F00D;
        auto_ack = 1'b0;
        for (int i = 0; i < 63; i++) begin
            bt = (i < 32) ? wa[31 - i] : wb[63 - i];
            send_bit(0, bt, 1'b0);
        end
        cyc(2'b01, {1'b0, wb[0]}, 2'b01, 1'b0, 1'b0);
        checks++; if (src_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_stall0: got %b expected 0", src_ready[0]); end
        cyc(2'b01, {1'b0, wb[0]}, 2'b01, 1'b0, 1'b0);
        checks++; if (src_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_stall1: got %b expected 0", src_ready[0]); end
        cyc(2'b01, {1'b0, wb[0]}, 2'b01, 1'b0, 1'b1);
        checks++; if (src_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_ready_on_ack: got %b expected 1", src_ready[0]); end
        cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        checks++; if (wr_req !== 1'b1) begin errors++; $display("FAIL bp_second_req: got %b expected 1", wr_req); end
        checks++; if (wr_data !== wb) begin errors++; $display("FAIL bp_second_data: got %h expected %h", wr_data, wb); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL bp_grant_release: got %b expected 00", grant); end
        cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
        cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        checks++; if (wr_addr !== BASE + 32'd8) begin errors++; $display("FAIL bp_addr: got %h expected %h", wr_addr, BASE + 32'd8); end
    endtask

    task automatic test_flush_partial();
        logic [4:0] bits;
        bits = 5'b10110;
        auto_ack = 1'b0;
        for (int i = 4; i >= 0; i--) send_bit(1, bits[i], (i == 0));
        cyc(2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        mdl_flush();
        cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        checks++; if (wr_req !== 1'b0) begin errors++; $display("FAIL fp_no_req_yet: got %b expected 0", wr_req); end
        cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        checks++; if (wr_req !== 1'b1) begin errors++; $display("FAIL fp_req: got %b expected 1", wr_req); end
        checks++; if (wr_data !== 32'hB000_0000) begin errors++; $display("FAIL fp_data: got %h expected b0000000", wr_data); end
        cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
        cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL fp_done_early: got %b expected 0", done); end
        cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL fp_done: got %b expected 1", done); end
        mdl_clear();
        cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL fp_done_pulse: got %b expected 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fp_busy: got %b expected 0", busy); end
        checks++; if (wr_addr !== BASE) begin errors++; $display("FAIL fp_addr_rewind: got %h expected %h", wr_addr, BASE); end
    endtask

    task automatic test_flush_empty();
        auto_ack = 1'b0;
        cyc(2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        checks++; if (done !== 1'b0 || wr_req !== 1'b0) begin errors++; $display("FAIL fe_c1: got done %b req %b expected 0 0", done, wr_req); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fe_busy: got %b expected 1", busy); end
        cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        checks++; if (done !== 1'b0 || wr_req !== 1'b0) begin errors++; $display("FAIL fe_c2: got done %b req %b expected 0 0", done, wr_req); end
        cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        checks++; if (done !== 1'b1 || wr_req !== 1'b0) begin errors++; $display("FAIL fe_done: got done %b req %b expected 1 0", done, wr_req); end
        cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL fe_done_pulse: got %b expected 0", done); end
        mdl_clear();
    endtask

    task automatic test_reset_mid();
        logic [31:0] wc;
        logic [7:0]  bb;
        wc = 32'h0BAD_BEEF;
        bb = 8'h3C;
        auto_ack = 1'b0;
        for (int i = 31; i >= 0; i--) send_bit(1, wc[i], 1'b0);
        cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        checks++; if (wr_req !== 1'b1 || grant !== 2'b10) begin errors++; $display("FAIL rm_pre: got req %b grant %b expected 1 10", wr_req, grant); end
        rst = 1'b1;
        #1;
        checks++; if (wr_req !== 1'b0)  begin errors++; $display("FAIL rm_wr_req: got %b expected 0", wr_req); end
        checks++; if (grant !== 2'b00)  begin errors++; $display("FAIL rm_grant: got %b expected 00", grant); end
        checks++; if (wr_addr !== BASE) begin errors++; $display("FAIL rm_addr: got %h expected %h", wr_addr, BASE); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rm_busy: got %b expected 0", busy); end
        sb_data.delete();
        sb_addr.delete();
        mdl_clear();
        cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 7; i >= 0; i--) send_bit(0, bb[i], (i == 0));
        do_flush();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_arbitration();
        test_back_to_back();
        test_flush_partial();
        test_flush_empty();
        test_reset_mid();
        checks++;
        if (sb_data.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d unwritten words, expected 0", sb_data.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
